// File: rtl/cpu_boot_pkg.sv
// Shared types for the CPU boot/run sequencer: FSM states, error codes,
// and the default HALT encoding.
package cpu_boot_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR_LO,
        ST_HDR_HI,
        ST_LD_LO,
        ST_LD_HI,
        ST_ARM,
        ST_RUN,
        ST_DONE,
        ST_ERR
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_LEN     = 2'd1,
        ERR_TIMEOUT = 2'd2
    } err_t;

    localparam logic [15:0] HALT_INSTR_DEFAULT = 16'hFFFF;

    // States in which the sequencer is parked and will honour a start pulse.
    function automatic logic is_parked(state_t s);
        return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERR);
    endfunction

endpackage

// File: rtl/rx_word_packer.sv
// Byte handshake and little-endian pair assembly for the boot stream.
// The low byte is latched on a lo-phase accept; a hi-phase accept forms the
// 16-bit pair combinationally, and, when storing, registers it as a
// one-cycle word pulse for the instruction RAM write port.
module rx_word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        ready,
    input  logic        hi_phase,
    input  logic        store,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        fire,
    output logic [15:0] pair,
    output logic        word_valid,
    output logic [15:0] word
);

    logic [7:0] lo_q;

    assign fire = rx_valid && ready;
    assign pair = {rx_data, lo_q};

    // Latch the low byte and emit a registered word pulse after a stored hi byte.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            lo_q       <= '0;
            word_valid <= 1'b0;
            word       <= '0;
        end else begin
            word_valid <= fire && hi_phase && store;
            if (fire && !hi_phase)
                lo_q <= rx_data;
            if (fire && hi_phase && store)
                word <= pair;
        end
    end

endmodule

// File: rtl/cpu_boot_seq.sv
// Boot/run sequencer: holds the CPU in reset while loading instruction RAM
// from a length-prefixed byte stream, then releases it and counts run cycles
// until HALT is fetched or the cycle limit expires.
module cpu_boot_seq
    import cpu_boot_pkg::*;
#(
    parameter int          IMEM_AW    = 10,
    parameter logic [15:0] HALT_INSTR = HALT_INSTR_DEFAULT,
    parameter int          MAX_CYCLES = 1000000,
    parameter int          CNT_W      = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               rx_valid,
    input  logic [7:0]         rx_data,
    output logic               rx_ready,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [15:0]        imem_wdata,
    output logic               cpu_reset,
    input  logic [31:0]        cpu_pc,
    input  logic [15:0]        cpu_instr,
    output logic               busy,
    output logic               done,
    output logic [1:0]         err_code,
    output logic [CNT_W-1:0]   cycle_count,
    output logic [31:0]        halt_pc
);

    localparam logic [CNT_W-1:0] LAST_RUN_CNT = CNT_W'(MAX_CYCLES - 1);

    state_t             state;
    logic [IMEM_AW-1:0] idx;
    logic [IMEM_AW-1:0] last_idx;
    logic               fire;
    logic [15:0]        pair;
    logic               len_bad;
    logic               cnt_sat;

    assign busy    = !is_parked(state);
    assign len_bad = (pair == 16'd0) || ({16'd0, pair} > (32'd1 << IMEM_AW));
    assign cnt_sat = &cycle_count;

    rx_word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .ready      (rx_ready),
        .hi_phase   ((state == ST_HDR_HI) || (state == ST_LD_HI)),
        .store      (state == ST_LD_HI),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .fire       (fire),
        .pair       (pair),
        .word_valid (imem_we),
        .word       (imem_wdata)
    );

    // Sequencer FSM with registered handshake, CPU reset, status and run counter.
    always_ff @(posedge clk) begin
        // NOTE: reset clears only control/status registers; the instruction RAM
        // behind the write port keeps whatever a partial load left in it.
        if (reset) begin
            state       <= ST_IDLE;
            cpu_reset   <= 1'b1;
            rx_ready    <= 1'b0;
            imem_addr   <= '0;
            idx         <= '0;
            last_idx    <= '0;
            done        <= 1'b0;
            err_code    <= ERR_NONE;
            cycle_count <= '0;
            halt_pc     <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state       <= ST_HDR_LO;
                        rx_ready    <= 1'b1;
                        done        <= 1'b0;
                        err_code    <= ERR_NONE;
                        cycle_count <= '0;
                        halt_pc     <= '0;
                    end
                end
                ST_HDR_LO: begin
                    if (fire)
                        state <= ST_HDR_HI;
                end
                ST_HDR_HI: begin
                    if (fire) begin
                        if (len_bad) begin
                            state    <= ST_ERR;
                            err_code <= ERR_LEN;
                            rx_ready <= 1'b0;
                        end else begin
                            state    <= ST_LD_LO;
                            idx      <= '0;
                            last_idx <= IMEM_AW'(pair - 16'd1);
                        end
                    end
                end
                ST_LD_LO: begin
                    if (fire)
                        state <= ST_LD_HI;
                end
                ST_LD_HI: begin
                    if (fire) begin
                        imem_addr <= idx;
                        if (idx == last_idx) begin
                            state    <= ST_ARM;
                            rx_ready <= 1'b0;
                        end else begin
                            idx   <= idx + IMEM_AW'(1);
                            state <= ST_LD_LO;
                        end
                    end
                end
                ST_ARM: begin
                    state     <= ST_RUN;
                    cpu_reset <= 1'b0;
                end
                ST_RUN: begin
                    if (cpu_instr == HALT_INSTR) begin
                        state     <= ST_DONE;
                        done      <= 1'b1;
                        halt_pc   <= cpu_pc;
                        cpu_reset <= 1'b1;
                        if (!cnt_sat)
                            cycle_count <= cycle_count + CNT_W'(1);
                    end else if (cycle_count == LAST_RUN_CNT) begin
                        state     <= ST_ERR;
                        err_code  <= ERR_TIMEOUT;
                        cpu_reset <= 1'b1;
                    end else if (!cnt_sat) begin
                        cycle_count <= cycle_count + CNT_W'(1);
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    cpu_reset <= 1'b1;
                    rx_ready  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_boot_seq.sv
// Self-checking bench for cpu_boot_seq: scoreboard of expected RAM writes,
// a trivial CPU model that walks the PC and presents HALT at a chosen PC,
// and status checks after each load/run.
module tb_cpu_boot_seq;

    localparam int AW   = 10;
    localparam int MAXC = 16;
    localparam int CW   = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [15:0]   imem_wdata;
    logic          cpu_reset;
    logic [31:0]   cpu_pc = 32'd0;
    logic [15:0]   cpu_instr;
    logic          busy;
    logic          done;
    logic [1:0]    err_code;
    logic [CW-1:0] cycle_count;
    logic [31:0]   halt_pc;

    cpu_boot_seq #(
        .IMEM_AW    (AW),
        .HALT_INSTR (16'hFFFF),
        .MAX_CYCLES (MAXC),
        .CNT_W      (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .cpu_reset   (cpu_reset),
        .cpu_pc      (cpu_pc),
        .cpu_instr   (cpu_instr),
        .busy        (busy),
        .done        (done),
        .err_code    (err_code),
        .cycle_count (cycle_count),
        .halt_pc     (halt_pc)
    );

    always #5 clk = ~clk;

    // CPU model: PC advances once per un-reset cycle; HALT presented at halt_at.
    logic [31:0] halt_at = 32'hFFFF_FFFF;
    always @(posedge clk) begin
        if (cpu_reset) cpu_pc <= 32'd0;
        else           cpu_pc <= cpu_pc + 32'd1;
    end
    assign cpu_instr = (!cpu_reset && cpu_pc == halt_at) ? 16'hFFFF : 16'h0000;

    int n_checks = 0;
    int n_pass   = 0;
    int runs     = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        logic [15:0]   data;
    } wr_t;
    wr_t sb[$];

    // Scoreboard: every RAM write must match the next expected (addr, data).
    always @(negedge clk) begin
        if (!reset && imem_we) begin
            if (sb.size() == 0) begin
                check("unexpected_we", {imem_addr, imem_wdata}, 64'hDEAD);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("wr_addr", imem_addr, e.addr);
                check("wr_data", imem_wdata, e.data);
                check("wr_cpu_held", cpu_reset, 1'b1);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        if (!cpu_reset) runs++;
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gap;
        int budget;
        gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        repeat (gap) begin
            @(negedge clk);
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
        end
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        budget   = 50;
        while (!rx_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) check("rx_accept_timeout", 0, 1);
        @(posedge clk);
    endtask

    task automatic send_word(input logic [AW-1:0] addr, input logic [15:0] w, input int max_gap);
        wr_t e;
        send_byte(w[7:0], max_gap);
        e.addr = addr;
        e.data = w;
        sb.push_back(e);
        send_byte(w[15:8], max_gap);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        rx_valid = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_end();
        int budget;
        budget = 200;
        while (busy && budget > 0) begin
            step();
            budget--;
        end
        if (budget == 0) check("run_end_timeout", 0, 1);
        rx_valid = 1'b0;
    endtask

    // Load a program: header then words, random byte gaps up to max_gap cycles.
    task automatic load(input logic [15:0] words[$], input int max_gap);
        logic [15:0] len;
        len = 16'(words.size());
        send_byte(len[7:0], max_gap);
        send_byte(len[15:8], max_gap);
        foreach (words[i]) send_word(AW'(i), words[i], max_gap);
    endtask

    initial begin
        logic [15:0] prog[$];
        #(2_000_000);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] prog[$];

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_cpu_reset", cpu_reset, 1'b1);
        check("rst_rx_ready", rx_ready, 1'b0);
        check("rst_imem_we", imem_we, 1'b0);
        check("rst_imem_addr", imem_addr, 0);
        check("rst_imem_wdata", imem_wdata, 0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err_code, 2'd0);
        check("rst_count", cycle_count, 0);
        check("rst_halt_pc", halt_pc, 0);
        reset = 1'b0;

        // Basic load 02 00 | 34 12 | FF FF, HALT at pc=4
        halt_at = 32'd4;
        pulse_start();
        check("start_busy", busy, 1'b1);
        check("start_rx_ready", rx_ready, 1'b1);
        prog = '{16'h1234, 16'hFFFF};
        load(prog, 0);
        runs = 0;
        step();
        rx_valid = 1'b0;
        check("arm_cpu_reset", cpu_reset, 1'b1);
        check("arm_rx_ready", rx_ready, 1'b0);
        step();
        check("run_cpu_reset", cpu_reset, 1'b0);
        check("run_busy", busy, 1'b1);
        wait_end();
        check("halt_done", done, 1'b1);
        check("halt_err", err_code, 2'd0);
        check("halt_pc", halt_pc, 32'd4);
        check("halt_count", cycle_count, 5);
        check("halt_runs", runs, 5);
        check("halt_cpu_reset", cpu_reset, 1'b1);
        check("sb_empty_basic", sb.size(), 0);

        // Length 0 -> ERR_LEN, no writes
        pulse_start();
        check("restart_clears_done", done, 1'b0);
        check("restart_clears_count", cycle_count, 0);
        check("restart_clears_halt_pc", halt_pc, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        step();
        rx_valid = 1'b0;
        check("len0_err", err_code, 2'd1);
        check("len0_busy", busy, 1'b0);
        check("len0_cpu_reset", cpu_reset, 1'b1);
        check("len0_rx_ready", rx_ready, 1'b0);

        // Length 1025 -> ERR_LEN
        pulse_start();
        check("err_start_clears", err_code, 2'd0);
        send_byte(8'h01, 0);
        send_byte(8'h04, 0);
        step();
        rx_valid = 1'b0;
        check("len1025_err", err_code, 2'd1);
        check("len1025_busy", busy, 1'b0);

        // Timeout; start pulses during LD_LO and RUN are ignored
        halt_at = 32'hFFFF_FFFF;
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        pulse_start();
        check("ldlo_start_ignored_busy", busy, 1'b1);
        send_word(0, 16'hA5A5, 0);
        send_word(1, 16'h0102, 0);
        runs = 0;
        step();
        rx_valid = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_end();
        check("to_err", err_code, 2'd2);
        check("to_done", done, 1'b0);
        check("to_count", cycle_count, 15);
        check("to_runs", runs, 16);
        check("to_cpu_reset", cpu_reset, 1'b1);
        check("sb_empty_to", sb.size(), 0);

        // HALT on the timeout cycle wins
        halt_at = 32'd15;
        pulse_start();
        prog = '{16'h0000};
        load(prog, 0);
        runs = 0;
        wait_end();
        check("tie_done", done, 1'b1);
        check("tie_err", err_code, 2'd0);
        check("tie_count", cycle_count, 16);
        check("tie_halt_pc", halt_pc, 32'd15);
        check("tie_runs", runs, 16);

        // Random rx_valid gaps give identical write sequence
        halt_at = 32'd2;
        pulse_start();
        check("done_start_clears", done, 1'b0);
        prog = '{16'h1111, 16'h2222, 16'h3333, 16'hBEEF, 16'hFFFF};
        load(prog, 3);
        runs = 0;
        wait_end();
        check("rand_done", done, 1'b1);
        check("rand_count", cycle_count, 3);
        check("sb_empty_rand", sb.size(), 0);

        // Reset in LD_HI after 3 words, then reload from word 0
        pulse_start();
        send_byte(8'h05, 0);
        send_byte(8'h00, 0);
        send_word(0, 16'hC001, 0);
        send_word(1, 16'hC002, 0);
        send_word(2, 16'hC003, 0);
        send_byte(8'h44, 0);
        @(negedge clk);
        rx_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 1'b0);
        check("abort_cpu_reset", cpu_reset, 1'b1);
        check("abort_rx_ready", rx_ready, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_err", err_code, 2'd0);
        check("abort_imem_addr", imem_addr, 0);
        check("abort_imem_we", imem_we, 1'b0);
        reset = 1'b0;
        check("sb_empty_abort", sb.size(), 0);
        halt_at = 32'd0;
        pulse_start();
        prog = '{16'h7777, 16'h8888};
        load(prog, 0);
        runs = 0;
        wait_end();
        check("reload_done", done, 1'b1);
        check("reload_count", cycle_count, 1);
        check("reload_halt_pc", halt_pc, 0);
        check("sb_empty_reload", sb.size(), 0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
